// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the byte-serial memory-bus scheduler: FSM encodings,
// access-size codes, the IO region match and the byte-count decode.
package mem_bus_arbiter_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_IF_RD = 3'd1;
  localparam logic [2:0] ST_LS_RD = 3'd2;
  localparam logic [2:0] ST_LS_WR = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // UART and other memory-mapped IO live where addr[17:16] is 2'b11.
  function automatic logic is_io_addr(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

  // Size code 3 is not a legal encoding and falls back to a word access.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Owns the 8-bit RAM/IO bus and splits fetch and load/store requests into
// per-byte bus cycles; data wins over fetch, jump flushes abort fetches.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  output logic [31:0] if_pc,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  logic [2:0]  state;
  logic [2:0]  cnt;
  logic [2:0]  req_n;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] asm_data;
  logic [31:0] asm_next;
  logic [31:0] step_addr;
  logic [1:0]  cap_idx;
  logic        io_hold;

  // RAM answers one cycle after the address, so the byte arriving at step
  // cnt belongs to the address issued two steps earlier.
  always_comb begin
    io_hold   = ls_we && is_io_addr(ls_addr) && io_buffer_full;
    cap_idx   = cnt[1:0] - 2'd2;
    step_addr = req_addr + {29'd0, cnt};
    asm_next  = asm_data;
    if (cnt >= 3'd2) asm_next[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      req_n     <= 3'd0;
      req_addr  <= ZeroWord;
      req_wdata <= ZeroWord;
      asm_data  <= ZeroWord;
      if_done   <= 1'b0;
      if_data   <= ZeroWord;
      if_pc     <= ZeroWord;
      ls_done   <= 1'b0;
      ls_rdata  <= ZeroWord;
      mem_dout  <= 8'h00;
      mem_a     <= ZeroWord;
      mem_wr    <= 1'b0;
    end else begin
      // NOTE: pulses and bus signals default to idle here and are overridden
      // below; with non-blocking assignments the last write in the block wins.
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_a    <= ZeroWord;
      mem_dout <= 8'h00;

      case (state)
        ST_IDLE: begin
          if (ls_req && !io_hold) begin
            req_addr  <= ls_addr;
            req_wdata <= ls_wdata;
            req_n     <= byte_count(ls_size);
            asm_data  <= ZeroWord;
            cnt       <= 3'd1;
            mem_a     <= ls_addr;
            if (ls_we) begin
              state    <= ST_LS_WR;
              mem_wr   <= 1'b1;
              mem_dout <= ls_wdata[7:0];
            end else begin
              state <= ST_LS_RD;
            end
          end else if (if_req && !flush) begin
            req_addr  <= if_addr;
            req_wdata <= ZeroWord;
            req_n     <= 3'd4;
            asm_data  <= ZeroWord;
            cnt       <= 3'd1;
            mem_a     <= if_addr;
            state     <= ST_IF_RD;
          end
        end

        ST_IF_RD, ST_LS_RD: begin
          if (state == ST_IF_RD && flush) begin
            // Bytes still in flight are simply never captured.
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            asm_data <= ZeroWord;
          end else begin
            asm_data <= asm_next;
            if (cnt < req_n) mem_a <= step_addr;
            if (cnt == req_n + 3'd1) begin
              state <= ST_DONE;
              cnt   <= 3'd0;
              if (state == ST_IF_RD) begin
                if_done <= 1'b1;
                if_data <= asm_next;
                if_pc   <= req_addr;
              end else begin
                ls_done  <= 1'b1;
                ls_rdata <= asm_next;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end

        ST_LS_WR: begin
          if (cnt < req_n) begin
            mem_wr   <= 1'b1;
            mem_a    <= step_addr;
            mem_dout <= req_wdata[{cnt[1:0], 3'b000} +: 8];
            cnt      <= cnt + 3'd1;
          end else begin
            ls_done <= 1'b1;
            state   <= ST_DONE;
            cnt     <= 3'd0;
          end
        end

        // One quiet cycle so requesters can drop or replace their request.
        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_done;
  logic [31:0] if_data;
  logic [31:0] if_pc;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = 2'd0;
  logic [31:0] ls_addr = 32'h0;
  logic [31:0] ls_wdata = 32'h0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int passed = 0;
  int total = 0;

  logic [7:0] ram [logic [31:0]];

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data), .if_pc(if_pc),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mem_a, mem_wr, mem_dout} !== 41'h0) $display("FAIL reset_bus: a=%h wr=%b dout=%h, want 0", mem_a, mem_wr, mem_dout);
    else passed++;
    total++;
    if ({if_done, ls_done, if_data, if_pc, ls_rdata} !== 98'h0)
      $display("FAIL reset_out: ifd=%b lsd=%b if_data=%h if_pc=%h ls_rdata=%h, want 0", if_done, ls_done, if_data, if_pc, ls_rdata);
    else passed++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0) $display("FAIL idle_after_reset: a=%h wr=%b, want 0/0", mem_a, mem_wr);
    else passed++;
  endtask

  task automatic test_fetch();
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    if_addr = 32'h100;
    if_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (mem_a !== 32'h100 + i || mem_wr !== 1'b0 || if_done !== 1'b0)
        $display("FAIL fetch_addr%0d: a=%h wr=%b done=%b, want %h/0/0", i, mem_a, mem_wr, if_done, 32'h100 + i);
      else passed++;
    end
    tick();
    total++;
    if (mem_a !== 32'h0 || if_done !== 1'b0) $display("FAIL fetch_gap: a=%h done=%b, want 0/0", mem_a, if_done);
    else passed++;
    tick();
    total++;
    if (if_done !== 1'b1 || if_data !== 32'h0000_0513 || if_pc !== 32'h100)
      $display("FAIL fetch_done: done=%b data=%h pc=%h, want 1/00000513/00000100", if_done, if_data, if_pc);
    else passed++;
    if_req = 1'b0;
    tick();
    total++;
    if (if_done !== 1'b0) $display("FAIL fetch_pulse: done=%b, want 0", if_done);
    else passed++;
    tick();
  endtask

  task automatic test_priority();
    ram[32'h2001] = 8'hFF; ram[32'h2002] = 8'h80;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'h2001;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    total++;
    if (mem_a !== 32'h2001) $display("FAIL prio_first: a=%h, want 00002001", mem_a);
    else passed++;
    tick();
    total++;
    if (mem_a !== 32'h2002) $display("FAIL prio_second: a=%h, want 00002002", mem_a);
    else passed++;
    tick();
    tick();
    total++;
    if (ls_done !== 1'b1 || ls_rdata !== 32'h0000_80FF || if_done !== 1'b0)
      $display("FAIL prio_load: ls_done=%b rdata=%h if_done=%b, want 1/000080ff/0", ls_done, ls_rdata, if_done);
    else passed++;
    ls_req = 1'b0;
    tick();
    total++;
    if (mem_a !== 32'h0) $display("FAIL prio_done_quiet: a=%h, want 0", mem_a);
    else passed++;
    tick();
    total++;
    if (mem_a !== 32'h100) $display("FAIL prio_fetch_grant: a=%h, want 00000100", mem_a);
    else passed++;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (if_done !== 1'b1 || if_data !== 32'h0000_0513)
      $display("FAIL prio_fetch_done: done=%b data=%h, want 1/00000513", if_done, if_data);
    else passed++;
    if_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_store_word();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h1000; ls_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (mem_wr !== 1'b1 || mem_a !== 32'h1000 + i || mem_dout !== exp_b[i] || ls_done !== 1'b0)
        $display("FAIL store_byte%0d: wr=%b a=%h dout=%h done=%b, want 1/%h/%h/0", i, mem_wr, mem_a, mem_dout, ls_done, 32'h1000 + i, exp_b[i]);
      else passed++;
    end
    tick();
    total++;
    if (ls_done !== 1'b1 || mem_wr !== 1'b0) $display("FAIL store_done: done=%b wr=%b, want 1/0", ls_done, mem_wr);
    else passed++;
    ls_req = 1'b0;
    tick();
    tick();
    total++;
    if (ram[32'h1000] !== 8'hEF || ram[32'h1003] !== 8'hDE)
      $display("FAIL store_ram: [1000]=%h [1003]=%h, want ef/de", ram[32'h1000], ram[32'h1003]);
    else passed++;
  endtask

  task automatic test_io_store();
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h3_0000; ls_wdata = 32'h0000_0041;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (mem_wr !== 1'b0 || mem_a !== 32'h0) $display("FAIL io_hold%0d: wr=%b a=%h, want 0/0", i, mem_wr, mem_a);
      else passed++;
    end
    io_buffer_full = 1'b0;
    tick();
    total++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h3_0000 || mem_dout !== 8'h41)
      $display("FAIL io_write: wr=%b a=%h dout=%h, want 1/00030000/41", mem_wr, mem_a, mem_dout);
    else passed++;
    tick();
    total++;
    if (ls_done !== 1'b1) $display("FAIL io_done: done=%b, want 1", ls_done);
    else passed++;
    ls_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h1200; ls_wdata = 32'h0000_0055;
    tick();
    tick();
    total++;
    if (ls_done !== 1'b1) $display("FAIL b2b_first_done: done=%b, want 1", ls_done);
    else passed++;
    ls_addr = 32'h1201; ls_wdata = 32'h0000_0066;
    tick();
    total++;
    if (mem_wr !== 1'b0 || ls_done !== 1'b0) $display("FAIL b2b_gap: wr=%b done=%b, want 0/0", mem_wr, ls_done);
    else passed++;
    tick();
    total++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h1201 || mem_dout !== 8'h66)
      $display("FAIL b2b_second: wr=%b a=%h dout=%h, want 1/00001201/66", mem_wr, mem_a, mem_dout);
    else passed++;
    ls_req = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_flush();
    ram[32'h104] = 8'h93; ram[32'h105] = 8'h00; ram[32'h106] = 8'h10; ram[32'h107] = 8'h00;
    ram[32'h200] = 8'hAA; ram[32'h201] = 8'hBB;
    if_req = 1'b1; if_addr = 32'h200;
    tick();
    tick();
    flush = 1'b1;
    tick();
    total++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || if_done !== 1'b0)
      $display("FAIL flush_idle: a=%h wr=%b done=%b, want 0/0/0", mem_a, mem_wr, if_done);
    else passed++;
    flush = 1'b0;
    if_addr = 32'h104;
    tick();
    total++;
    if (mem_a !== 32'h104) $display("FAIL flush_regrant: a=%h, want 00000104", mem_a);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (if_done !== 1'b0) $display("FAIL flush_no_done%0d: done=%b, want 0", i, if_done);
      else passed++;
    end
    tick();
    total++;
    if (if_done !== 1'b1 || if_data !== 32'h0010_0093 || if_pc !== 32'h104)
      $display("FAIL flush_refetch: done=%b data=%h pc=%h, want 1/00100093/00000104", if_done, if_data, if_pc);
    else passed++;
    if_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_flush_last();
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    total++;
    if (if_done !== 1'b0 || mem_a !== 32'h0) $display("FAIL flush_last: done=%b a=%h, want 0/0", if_done, mem_a);
    else passed++;
    flush = 1'b0;
    if_req = 1'b0;
    tick();
    total++;
    if (if_done !== 1'b0) $display("FAIL flush_last_after: done=%b, want 0", if_done);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_store();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h1100; ls_wdata = 32'h1122_3344;
    tick();
    tick();
    total++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h1101 || mem_dout !== 8'h33)
      $display("FAIL rst_store_byte1: wr=%b a=%h dout=%h, want 1/00001101/33", mem_wr, mem_a, mem_dout);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({mem_a, mem_wr, mem_dout, ls_done, if_done} !== 43'h0)
      $display("FAIL rst_mid_store: a=%h wr=%b dout=%h lsd=%b ifd=%b, want 0", mem_a, mem_wr, mem_dout, ls_done, if_done);
    else passed++;
    ls_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ls_done !== 1'b0 || mem_wr !== 1'b0) $display("FAIL rst_no_done%0d: done=%b wr=%b, want 0/0", i, ls_done, mem_wr);
      else passed++;
    end
    total++;
    if (ram[32'h1100] !== 8'h44 || ram.exists(32'h1101) || ram.exists(32'h1102))
      $display("FAIL rst_partial: [1100]=%h has1101=%0d has1102=%0d, want 44/0/0", ram[32'h1100], ram.exists(32'h1101), ram.exists(32'h1102));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store_word();
    test_io_store();
    test_back_to_back();
    test_flush();
    test_flush_last();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
